// File: rtl/compare_arbiter.sv
// compare_arbiter: shares one unsigned magnitude comparator among NUM_REQ
// requesters. Each transaction runs IDLE -> CMP -> DONE, which gives one
// result every three cycles under continuous load.
// Optional feature macro: COMPARE_ARB_RR_EN
//   defined   -> round-robin arbitration using a rotating priority pointer
//   undefined -> fixed priority, the lowest requester index wins
module compare_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_flat,
  input  logic [NUM_REQ*WIDTH-1:0] b_flat,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     less,
  output logic                     equal,
  output logic                     greater,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [IDX_W-1:0]   win_r;
  logic [IDX_W-1:0]   win_sel;
  logic               found;
  int                 scan_idx;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [NUM_REQ-1:0] grant_sel;
`ifdef COMPARE_ARB_RR_EN
  logic [IDX_W-1:0]   ptr;
`endif

  // Arbitration: scan the request vector starting at the current priority.
  always_comb begin
    win_sel  = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef COMPARE_ARB_RR_EN
      scan_idx = int'(ptr) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
`else
      scan_idx = i;
`endif
      if (!found && req[IDX_W'(scan_idx)]) begin
        found   = 1'b1;
        win_sel = IDX_W'(scan_idx);
      end
    end
  end

  // Operand mux and one-hot grant for the selected winner.
  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    grant_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_sel == IDX_W'(i)) begin
        a_sel        = a_flat[i*WIDTH +: WIDTH];
        b_sel        = b_flat[i*WIDTH +: WIDTH];
        grant_sel[i] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: only IDLE waits; CMP and DONE always advance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CMP;
      CMP:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction registers: latch operands at grant, capture result in CMP,
  // release the grant (and advance priority) when leaving DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      win_r   <= '0;
      less    <= 1'b0;
      equal   <= 1'b0;
      greater <= 1'b0;
`ifdef COMPARE_ARB_RR_EN
      ptr     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= grant_sel;
            a_r   <= a_sel;
            b_r   <= b_sel;
            win_r <= win_sel;
          end
        end
        CMP: begin
          less    <= (a_r <  b_r);
          equal   <= (a_r == b_r);
          greater <= (a_r >  b_r);
        end
        DONE: begin
          grant <= '0;
`ifdef COMPARE_ARB_RR_EN
          if (win_r == IDX_W'(NUM_REQ - 1)) ptr <= '0;
          else                              ptr <= win_r + 1'b1;
`endif
        end
        default: grant <= '0;
      endcase
    end
  end

  // Completion pulse follows the held grant for the single DONE cycle.
  assign done = (state == DONE) ? grant : '0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_compare_arbiter.sv
// Self-checking bench for compare_arbiter: directed scenarios followed by
// randomized traffic, checked every cycle against a transaction-level model.
// Honours COMPARE_ARB_RR_EN the same way as the design.
module tb_compare_arbiter;

  localparam int NR = 4;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*W-1:0] a_flat;
  logic [NR*W-1:0] b_flat;
  logic [NR-1:0] grant;
  logic [NR-1:0] done;
  logic          less;
  logic          equal;
  logic          greater;
  logic          busy;

  compare_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_flat  (a_flat),
    .b_flat  (b_flat),
    .grant   (grant),
    .done    (done),
    .less    (less),
    .equal   (equal),
    .greater (greater),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Requester-side state
  logic [W-1:0] opa [NR];
  logic [W-1:0] opb [NR];
  bit           auto_re [NR];

  int n_chk;
  int n_pass;

  // Reference model: transaction phase (0 idle, 1 compare, 2 done),
  // served requester, its sampled operands and the last result.
  int           ph;
  int           win;
`ifdef COMPARE_ARB_RR_EN
  int           ptr;
`endif
  logic [W-1:0] la;
  logic [W-1:0] lb;
  logic         el;
  logic         ee;
  logic         eg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic pack();
    for (int i = 0; i < NR; i++) begin
      a_flat[i*W +: W] = opa[i];
      b_flat[i*W +: W] = opb[i];
    end
  endtask

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    opa[i] = a;
    opb[i] = b;
    pack();
    req[i] = 1'b1;
  endtask

  function automatic int pick(input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++) begin
      int idx;
`ifdef COMPARE_ARB_RR_EN
      idx = (ptr + k) % NR;
`else
      idx = k;
`endif
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    ph  = 0;
    win = 0;
`ifdef COMPARE_ARB_RR_EN
    ptr = 0;
`endif
    la  = '0;
    lb  = '0;
    el  = 1'b0;
    ee  = 1'b0;
    eg  = 1'b0;
  endtask

  task automatic model_edge();
    case (ph)
      0: if (req != '0) begin
        win = pick(req);
        la  = opa[win];
        lb  = opb[win];
        ph  = 1;
      end
      1: begin
        el = (la < lb);
        ee = (la == lb);
        eg = (la > lb);
        ph = 2;
      end
      default: begin
`ifdef COMPARE_ARB_RR_EN
        ptr = (win + 1) % NR;
`endif
        ph = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [NR-1:0] ge;
    ge = (ph != 0) ? NR'(1 << win) : '0;
    chk("grant",  32'(grant), 32'(ge));
    chk("done",   32'(done),  (ph == 2) ? 32'(ge) : 32'h0);
    chk("busy",   32'(busy),  (ph != 0) ? 32'h1 : 32'h0);
    chk("result", 32'({less, equal, greater}), 32'({el, ee, eg}));
  endtask

  // One clock: model follows the edge, finished requester drops req
  // (re-raising at once if it is in continuous mode), outputs checked at negedge.
  task automatic cycle();
    int fin;
    @(posedge clk);
    fin = (!rst && ph == 2) ? win : -1;
    if (!rst) model_edge();
    #1;
    if (fin >= 0) begin
      req[fin] = 1'b0;
      if (auto_re[fin]) raise(fin, W'($urandom), W'($urandom));
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic random_step();
    for (int i = 0; i < NR; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = ($urandom_range(3) == 0) ? a : W'($urandom);
      if (!req[i]) begin
        if ($urandom_range(2) == 0) raise(i, a, b);
      end else if (ph != 0 && win == i) begin
        // in-flight requester may scramble operands and drop req
        if ($urandom_range(3) == 0) begin
          opa[i] = a;
          opb[i] = b;
          pack();
          req[i] = 1'b0;
        end
      end else if ($urandom_range(5) == 0) begin
        opa[i] = a;
        opb[i] = b;
        pack();
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    req    = '0;
    for (int i = 0; i < NR; i++) begin
      opa[i]     = '0;
      opb[i]     = '0;
      auto_re[i] = 1'b0;
    end
    pack();
    model_reset();

    // Reset state
    #2;
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs();

    // Single requester, A < B
    raise(0, 4'd10, 4'd12);
    cycle();
    chk("t1_grant", 32'(grant), 32'h1);
    cycle();
    chk("t1_res",  32'({less, equal, greater}), 32'h4);
    chk("t1_done", 32'(done), 32'h1);
    cycle();
    idle(2);

    // A > B, then A == B; results hold in between
    raise(1, 4'd15, 4'd11);
    idle(2);
    chk("t2_gt", 32'({less, equal, greater}), 32'h1);
    idle(3);
    chk("t2_hold", 32'({less, equal, greater}), 32'h1);
    raise(2, 4'd10, 4'd10);
    idle(2);
    chk("t2_eq",   32'({less, equal, greater}), 32'h2);
    chk("t2_done", 32'(done), 32'h4);
    idle(3);

    // All requesters continuously active
    for (int i = 0; i < NR; i++) begin
      auto_re[i] = 1'b1;
      raise(i, W'(i * 3 + 1), W'(13 - i * 4));
    end
    idle(16);
    for (int i = 0; i < NR; i++) auto_re[i] = 1'b0;
    idle(16);

    // Reset asserted during the compare phase of requester 3
    raise(3, 4'd5, 4'd9);
    cycle();
    chk("t4_cmp_grant", 32'(grant), 32'h8);
    rst = 1'b1;
    #1;
    model_reset();
    chk("t4_rst_grant", 32'(grant), 32'h0);
    chk("t4_rst_busy",  32'(busy), 32'h0);
    chk("t4_rst_done",  32'(done), 32'h0);
    chk("t4_rst_res",   32'({less, equal, greater}), 32'h0);
    cycle();
    rst = 1'b0;
    idle(2);
    chk("t4_restart_done", 32'(done), 32'h8);
    chk("t4_restart_res",  32'({less, equal, greater}), 32'h4);
    idle(2);

    // Operands changed and req dropped while the comparison is in flight
    raise(1, 4'd3, 4'd9);
    cycle();
    opa[1] = 4'd12;
    opb[1] = 4'd2;
    pack();
    req[1] = 1'b0;
    cycle();
    chk("t5_latched", 32'({less, equal, greater}), 32'h4);
    chk("t5_done",    32'(done), 32'h2);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      random_step();
      cycle();
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
